// File: rtl/dab_param_loader_pkg.sv
// Shared constants, FSM encoding and field types for the DAB parameter loader.
package dab_param_loader_pkg;

   localparam logic [7:0]  HDR_BYTE    = 8'hA5;
   localparam int unsigned FRAME_LEN   = 10;
   localparam int unsigned PAYLOAD_LEN = FRAME_LEN - 2;

   // Field widths seen by the modulation top
   localparam int unsigned T_W   = 9;
   localparam int unsigned PHI_W = 9;
   localparam int unsigned FS_W  = 19;
   localparam int unsigned DT_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PAYLOAD,
      S_CHECK,
      S_STAGE
   } state_t;

   // Payload exactly as received (bytes 1..8)
   typedef struct packed {
      logic [7:0]  t1;
      logic [7:0]  t2;
      logic [15:0] phi;
      logic [23:0] fs;
      logic [7:0]  dt;
   } raw_payload_t;

   // Clamped parameter set, used for both shadow and active copies
   typedef struct packed {
      logic signed [T_W-1:0]   t1;
      logic signed [T_W-1:0]   t2;
      logic signed [PHI_W-1:0] phi;
      logic signed [FS_W-1:0]  fs;
      logic [DT_W-1:0]         dt;
   } param_set_t;

endpackage

// File: rtl/dab_param_loader_if.sv
// Received-byte stream from the UART receiver.
interface dab_param_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (output rx_data, output rx_valid);
   modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/dab_param_clamp.sv
// Combinational saturation of a raw payload into the clamped parameter set.
module dab_param_clamp
   import dab_param_loader_pkg::*;
#(
   parameter int unsigned FS_MIN = 500,
   parameter int unsigned FS_MAX = 250000
) (
   input  raw_payload_t raw,
   output param_set_t   clamped
);

   logic signed [15:0] phi_s;

   // Zero-extend taus, saturate phi and fs, force deadtime to at least 1
   always_comb begin
      clamped    = '0;
      phi_s      = signed'(raw.phi);
      clamped.t1 = signed'({1'b0, raw.t1});
      clamped.t2 = signed'({1'b0, raw.t2});

      if (phi_s < -16'sd255)
         clamped.phi = -9'sd255;
      else if (phi_s > 16'sd255)
         clamped.phi = 9'sd255;
      else
         clamped.phi = phi_s[PHI_W-1:0];

      if (raw.fs < 24'(FS_MIN))
         clamped.fs = FS_W'(FS_MIN);
      else if (raw.fs > 24'(FS_MAX))
         clamped.fs = FS_W'(FS_MAX);
      else
         clamped.fs = raw.fs[FS_W-1:0];

      clamped.dt = (raw.dt == 8'd0) ? 8'd1 : raw.dt;
   end

endmodule

// File: rtl/dab_param_loader.sv
// DAB modulation parameter loader: framed UART bytes -> shadow set -> active
// set, committed on a rising edge of the modulator period trigger.
// Optional inter-byte timeout: define DAB_LOADER_TIMEOUT_EN.
module dab_param_loader
   import dab_param_loader_pkg::*;
#(
   parameter int unsigned FS_MIN         = 500,
   parameter int unsigned FS_MAX         = 250000,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned T1_RST         = 255,
   parameter int unsigned T2_RST         = 147,
   parameter int          PHI_RST        = -9,
   parameter int unsigned FS_RST         = 50000,
   parameter int unsigned DT_RST         = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   dab_param_loader_if.slave       rx,
   input  logic                    trigger,
   output logic signed [T_W-1:0]   t1,
   output logic signed [T_W-1:0]   t2,
   output logic signed [PHI_W-1:0] phi,
   output logic signed [FS_W-1:0]  fs_DAB,
   output logic [DT_W-1:0]         deadtime,
   output logic                    pending,
   output logic                    frame_ok,
   output logic                    frame_err,
   output logic                    commit
);

   localparam param_set_t RST_SET = '{
      t1:  T_W'(T1_RST),
      t2:  T_W'(T2_RST),
      phi: PHI_W'(PHI_RST),
      fs:  FS_W'(FS_RST),
      dt:  DT_W'(DT_RST)
   };

   state_t       state, state_nxt;
   logic [2:0]   idx;
   logic [7:0]   chk;
   logic [7:0]   pbuf [PAYLOAD_LEN];
   raw_payload_t raw;
   param_set_t   clamped, shadow, active;
   logic         trig_d, trig_rise, busy, cksum_err, to_hit;

   assign trig_rise = trigger & ~trig_d;
   assign busy      = (state == S_PAYLOAD) || (state == S_CHECK);
   assign cksum_err = (state == S_CHECK) && rx.rx_valid && (rx.rx_data != chk);

   assign raw = '{
      t1:  pbuf[0],
      t2:  pbuf[1],
      phi: {pbuf[2], pbuf[3]},
      fs:  {pbuf[4], pbuf[5], pbuf[6]},
      dt:  pbuf[7]
   };

   dab_param_clamp #(
      .FS_MIN (FS_MIN),
      .FS_MAX (FS_MAX)
   ) u_clamp (
      .raw     (raw),
      .clamped (clamped)
   );

`ifdef DAB_LOADER_TIMEOUT_EN
   logic [31:0] to_cnt;

   // Inter-byte timer: cleared by every byte and whenever no frame is open
   always_ff @(posedge clk) begin
      if (rst || rx.rx_valid || !busy)
         to_cnt <= '0;
      else if (to_cnt != 32'(TIMEOUT_CYCLES))
         to_cnt <= to_cnt + 32'd1;
   end

   assign to_hit = busy && !rx.rx_valid && (to_cnt == 32'(TIMEOUT_CYCLES));
`else
   assign to_hit = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Frame parser next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:
            if (rx.rx_valid && rx.rx_data == HDR_BYTE) state_nxt = S_PAYLOAD;
         S_PAYLOAD:
            if (rx.rx_valid && idx == 3'(PAYLOAD_LEN - 1)) state_nxt = S_CHECK;
         S_CHECK:
            if (rx.rx_valid) state_nxt = cksum_err ? S_IDLE : S_STAGE;
         S_STAGE:
            state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
      if (to_hit) state_nxt = S_IDLE;
   end

   // Payload byte capture
   always_ff @(posedge clk) begin
      if (state == S_PAYLOAD && rx.rx_valid) pbuf[idx] <= rx.rx_data;
   end

   // Index/checksum, shadow and active sets, status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         chk       <= '0;
         trig_d    <= 1'b0;
         shadow    <= RST_SET;
         active    <= RST_SET;
         pending   <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         commit    <= 1'b0;
      end else begin
         trig_d    <= trigger;
         frame_ok  <= (state == S_STAGE);
         frame_err <= cksum_err | to_hit;
         commit    <= trig_rise & pending;

         if (state == S_IDLE) begin
            idx <= '0;
            chk <= '0;
         end else if (state == S_PAYLOAD && rx.rx_valid) begin
            idx <= idx + 3'd1;
            chk <= chk ^ rx.rx_data;
         end

         // Same-edge STAGE and trigger: active gets the old shadow (if any),
         // the new frame lands in shadow and stays pending for the next edge.
         if (trig_rise && pending) active <= shadow;
         if (state == S_STAGE) begin
            shadow  <= clamped;
            pending <= 1'b1;
         end else if (trig_rise && pending) begin
            pending <= 1'b0;
         end
      end
   end

   assign t1       = active.t1;
   assign t2       = active.t2;
   assign phi      = active.phi;
   assign fs_DAB   = active.fs;
   assign deadtime = active.dt;

endmodule

// File: tb/tb_dab_param_loader.sv
// Directed self-checking bench for dab_param_loader.
module tb_dab_param_loader;
   import dab_param_loader_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    trigger;
   logic signed [T_W-1:0]   t1, t2;
   logic signed [PHI_W-1:0] phi;
   logic signed [FS_W-1:0]  fs_DAB;
   logic [DT_W-1:0]         deadtime;
   logic                    pending, frame_ok, frame_err, commit;

   int total = 0;
   int bad   = 0;
   int n_ok = 0, n_err = 0, n_commit = 0;
   int ok0, err0, cm0;

   dab_param_loader_if rx_if ();

   dab_param_loader #(
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx_if),
      .trigger   (trigger),
      .t1        (t1),
      .t2        (t2),
      .phi       (phi),
      .fs_DAB    (fs_DAB),
      .deadtime  (deadtime),
      .pending   (pending),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .commit    (commit)
   );

   always #5 clk = ~clk;

   // Pulse counters
   always @(posedge clk) begin
      if (frame_ok)  n_ok     <= n_ok + 1;
      if (frame_err) n_err    <= n_err + 1;
      if (commit)    n_commit <= n_commit + 1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input int e_t1, input int e_t2,
                            input int e_phi, input int e_fs, input int e_dt);
      check({tag, ".t1"},  int'(t1),       e_t1);
      check({tag, ".t2"},  int'(t2),       e_t2);
      check({tag, ".phi"}, int'(phi),      e_phi);
      check({tag, ".fs"},  int'(fs_DAB),   e_fs);
      check({tag, ".dt"},  int'(deadtime), e_dt);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_if.rx_valid = 1'b1;
      rx_if.rx_data  = b;
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
   endtask

   // p holds bytes 1..8 MSB first; checksum is computed here and XORed with xmask
   task automatic send_frame(input logic [63:0] p, input logic [7:0] xmask,
                             input bit trig_on_stage);
      logic [7:0] c = 8'h00;
      logic [7:0] b;
      send_byte(HDR_BYTE);
      for (int i = 0; i < 8; i++) begin
         b = p[63 - 8*i -: 8];
         c = c ^ b;
         send_byte(b);
      end
      send_byte(c ^ xmask);
      if (trig_on_stage) begin
         trigger = 1'b1;
         @(negedge clk);
         trigger = 1'b0;
         repeat (2) @(negedge clk);
      end else begin
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic pulse_trigger();
      @(negedge clk);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic snap();
      ok0  = n_ok;
      err0 = n_err;
      cm0  = n_commit;
   endtask

   initial begin
      rst = 1'b1;
      trigger = 1'b0;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check_out("rst", 255, 147, -9, 50000, 10);
      check("rst.pending", int'(pending), 0);

      // Basic frame, then commit
      snap();
      send_frame(64'h64C8_0032_00C3_5005, 8'h00, 1'b0);
      check("a.ok", n_ok - ok0, 1);
      check("a.pending", int'(pending), 1);
      check("a.hold_t1", int'(t1), 255);
      pulse_trigger();
      check_out("a", 100, 200, 50, 50000, 5);
      check("a.commit", n_commit - cm0, 1);
      check("a.pending_clr", int'(pending), 0);

      // Bad checksum
      snap();
      send_frame(64'h64C8_0032_00C3_5005, 8'h01, 1'b0);
      check("e.err", n_err - err0, 1);
      check("e.ok", n_ok - ok0, 0);
      check("e.pending", int'(pending), 0);
      pulse_trigger();
      check("e.commit", n_commit - cm0, 0);
      check_out("e", 100, 200, 50, 50000, 5);

      // Clamp low side
      send_frame(64'h0102_FE00_0000_6400, 8'h00, 1'b0);
      pulse_trigger();
      check_out("cl1", 1, 2, -255, 500, 1);

      // Clamp high side
      send_frame(64'hFF00_0400_0FFF_FF07, 8'h00, 1'b0);
      pulse_trigger();
      check_out("cl2", 255, 0, 255, 250000, 7);

      // Two frames before one edge: last wins; header value inside payload is data
      snap();
      send_frame(64'h0A0B_0001_0001_0002, 8'h00, 1'b0);
      send_frame(64'hA514_FFF6_0010_0003, 8'h00, 1'b0);
      check("m.ok", n_ok - ok0, 2);
      pulse_trigger();
      check_out("m", 165, 20, -10, 4096, 3);
      check("m.commit", n_commit - cm0, 1);

      // STAGE coinciding with an edge while nothing is pending
      snap();
      send_frame(64'h1E1F_0080_0020_0004, 8'h00, 1'b1);
      check("s0.commit", n_commit - cm0, 0);
      check("s0.pending", int'(pending), 1);
      check("s0.hold_t1", int'(t1), 165);
      pulse_trigger();
      check_out("s0", 30, 31, 128, 8192, 4);

      // STAGE coinciding with an edge while a frame is pending
      snap();
      send_frame(64'h2829_FF01_0030_0006, 8'h00, 1'b0);
      send_frame(64'h3233_00FF_03D0_9008, 8'h00, 1'b1);
      check("s1.commit", n_commit - cm0, 1);
      check("s1.pending", int'(pending), 1);
      check_out("s1", 40, 41, -255, 12288, 6);
      pulse_trigger();
      check_out("s1n", 50, 51, 255, 250000, 8);
      check("s1n.pending", int'(pending), 0);

      // Stalled frame
      snap();
      send_byte(HDR_BYTE);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      repeat (70) @(negedge clk);
`ifdef DAB_LOADER_TIMEOUT_EN
      check("to.err", n_err - err0, 1);
      snap();
      send_frame(64'h0708_0000_0001_F4FF, 8'h00, 1'b0);
      check("to.ok", n_ok - ok0, 1);
      pulse_trigger();
      check_out("to", 7, 8, 0, 500, 255);
`else
      check("to.no_err", n_err - err0, 0);
      check("to.pending", int'(pending), 0);
`endif

      // Reset mid-frame
      send_byte(HDR_BYTE);
      send_byte(8'h11);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_out("rr", 255, 147, -9, 50000, 10);
      check("rr.pending", int'(pending), 0);
      snap();
      send_frame(64'h0708_0000_0001_F4FF, 8'h00, 1'b0);
      check("rr.ok", n_ok - ok0, 1);
      pulse_trigger();
      check_out("rr", 7, 8, 0, 500, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dab_param_loader.md
Name: dab_param_loader

Overview:
- Upstream of the DAB modulation top: receives modulation settings as a framed byte stream from a UART receiver and range-checks them.
- Holds the settings in a shadow register set, then commits them atomically to the active outputs that drive t1, t2, phi, fs_DAB and deadtime.
- Commit happens only on a rising edge of the modulator's period trigger, so the bridges never see a half-updated set.

Parameters:
- FS_MIN, 500: lower clamp for fs_DAB in Hz.
- FS_MAX, 250000: upper clamp for fs_DAB in Hz.
- TIMEOUT_CYCLES, 100000: inter-byte timeout in clk cycles (only used with the optional feature).
- T1_RST, 255: reset value of t1.
- T2_RST, 147: reset value of t2.
- PHI_RST, -9: reset value of phi.
- FS_RST, 50000: reset value of fs_DAB.
- DT_RST, 10: reset value of deadtime.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- trigger  in  1  period trigger from the modulator, synchronous to clk.
- t1  out  9 signed  active tau1, 0..255.
- t2  out  9 signed  active tau2, 0..255.
- phi  out  9 signed  active phase shift, -255..255.
- fs_DAB  out  19 signed  active switching frequency in Hz.
- deadtime  out  8  active deadtime, >=1.
- pending  out  1  shadow set holds an uncommitted frame.
- frame_ok  out  1  one-cycle pulse: valid frame accepted.
- frame_err  out  1  one-cycle pulse: checksum error or timeout.
- commit  out  1  one-cycle pulse: shadow copied to active outputs.

Behaviour:
- Reset (synchronous): active and shadow sets = *_RST values; pending=0; frame_ok, frame_err, commit = 0; FSM = IDLE; trigger history register = 0.
- Frame format is 10 bytes, MSB first:
  - byte 0: 0xA5 header.
  - byte 1: t1, unsigned.
  - byte 2: t2, unsigned.
  - bytes 3-4: phi, 16-bit two's complement.
  - bytes 5-7: fs, 24-bit unsigned.
  - byte 8: deadtime.
  - byte 9: checksum = XOR of bytes 1..8.
- FSM states:
  - IDLE: waits for rx_valid with rx_data=0xA5; other bytes are ignored. Go to PAYLOAD, idx=0, chk=0.
  - PAYLOAD: each rx_valid stores the byte at position idx and sets chk^=byte. When idx=7 go to CHECK. A 0xA5 byte here is data, not a re-sync.
  - CHECK: next rx_valid byte is compared with chk. Match: go to STAGE. Mismatch: frame_err=1 next cycle, shadow untouched, go to IDLE.
  - STAGE (1 cycle): write clamped values to shadow; pending=1; frame_ok=1; go to IDLE.
- Latency:
  - Checksum byte accepted at cycle N: frame_ok and pending high at N+2; shadow valid at N+2.
  - A header byte arriving during the STAGE cycle is dropped.
- Clamp rules, applied in STAGE:
  - t1 and t2: zero-extended to 9 bits.
  - phi: saturate to [-255, 255], then truncate to 9 bits.
  - fs: saturate to [FS_MIN, FS_MAX].
  - deadtime: 0 becomes 1.
- Commit:
  - Rising edge = trigger=1 and trigger_d=0.
  - Edge at cycle M with pending=1: active <= shadow, commit=1, and pending=0 at M+1.
  - Edge with pending=0: no change, no commit pulse.
- Simultaneous STAGE and trigger edge:
  - Active takes the pre-STAGE shadow only if pending was already 1.
  - The new shadow is written and pending ends at 1.
  - Net effect: the new frame is always held for the next edge.
- Several frames before one edge: the last frame wins.
- rst mid-frame: partial frame discarded; active outputs return to *_RST values.

Optional Feature:
- Macro: DAB_LOADER_TIMEOUT_EN.
- Defined: a counter clears on every rx_valid and counts while in PAYLOAD or CHECK. When it reaches TIMEOUT_CYCLES the FSM goes to IDLE and frame_err pulses once; shadow and pending are untouched.
- Undefined: no counter; the FSM waits indefinitely mid-frame and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package holds:
  - header constant 0xA5 and frame length 10;
  - FSM state encoding (IDLE, PAYLOAD, CHECK, STAGE);
  - the field widths 9/9/9/19/8 used by the modulation top.
- One natural sub-module, dab_param_clamp: combinational saturation from the raw payload to the clamped field set, instantiated once in STAGE.

Test Plan:
- Reset, then hold trigger low -> outputs t1=255, t2=147, phi=-9, fs_DAB=50000, deadtime=10; pending=0.
- Frame A5 64 C8 00 32 00 C3 50 05 + correct XOR, then trigger edge -> frame_ok pulse, pending=1. After the edge: t1=100, t2=200, phi=50, fs_DAB=50000, deadtime=5; commit pulse; pending=0.
- Same frame with the checksum byte XOR 0x01 -> frame_err pulse; pending=0; outputs unchanged after a trigger edge.
- Clamping: frame with phi=0xFE00 (-512), fs=0x000064 (100), deadtime=0 -> after commit phi=-255, fs_DAB=500, deadtime=1. Frame with phi=0x0400 (1024) and fs=0x0FFFFF -> phi=255, fs_DAB=250000.
- Two valid frames before one edge, then STAGE coinciding with a second edge -> first commit carries frame 2; pending stays 1; frame 3 commits on the following edge.
- With DAB_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=50: send header + 3 bytes, then idle for 50 cycles -> frame_err pulse, FSM in IDLE, a following full frame is accepted. Without the macro, no frame_err is raised.
